// File: rtl/uart_pkg.sv
// Shared types and constants for the UART message sequencer.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_WAIT = 2'b11
    } state_t;

    localparam logic [7:0]  C_CR      = 8'h0d;
    localparam logic [7:0]  C_LF      = 8'h0a;
    localparam logic [31:0] C_DEF_MSG = 32'h48454c4f;

endpackage

// File: rtl/uart_pend_counter.sv
// Saturating up/down counter of queued message requests; flags an overflow
// when a request arrives while full and nothing is being consumed.
module uart_pend_counter #(
    parameter int unsigned PEND_MAX = 3
) (
    input  logic clk_x4,
    input  logic rst_x,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic ovf
);

    localparam int unsigned W = $clog2(PEND_MAX + 1);

    logic [W-1:0] cnt;

    assign nonzero = (cnt != '0);
    assign ovf     = inc & ~dec & (cnt == W'(PEND_MAX));

    // inc and dec together leave the count unchanged
    always_ff @(posedge clk_x4) begin
        if (rst_x) begin
            cnt <= '0;
        end else if (inc && !dec && !ovf) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Replays a parametrised message into the UART TX handshake on each RX trigger byte.
// Define UART_MSG_CRLF_EN to append CR LF to every message.
module uart_msg_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned          MSG_LEN    = 4,
    parameter logic [MSG_LEN*8-1:0] MSG        = C_DEF_MSG,
    parameter logic [7:0]           TRIG       = C_CR,
    parameter int unsigned          PEND_MAX   = 3,
    parameter int unsigned          TMO_CYCLES = 64
) (
    input  logic       clk_x4,
    input  logic       rst_x,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_rx_error,
    input  logic       i_tx_error,
    input  logic       i_tx_busy,
    input  logic       i_clear,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic [7:0] o_data,
    output logic       o_active,
    output logic       o_tx_error,
    output logic       o_rx_error,
    output logic       o_pend_ovf
);

`ifdef UART_MSG_CRLF_EN
    localparam int unsigned NBYTES = MSG_LEN + 2;
`else
    localparam int unsigned NBYTES = MSG_LEN;
`endif
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TMO_W-1:0] tmo;
    logic             busy_d;
    logic             busy_rise;
    logic             busy_fall;
    logic             trig;
    logic             start;
    logic             pend_nz;
    logic             pend_ovf;
    logic [7:0]       msg_rom [2**IDX_W];

    // Byte 0 is the MSB byte of MSG; unused slots read as zero
    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
        if (g < MSG_LEN) begin : g_msg
            assign msg_rom[g] = MSG[8*(MSG_LEN-1-g) +: 8];
        end
`ifdef UART_MSG_CRLF_EN
        else if (g == MSG_LEN) begin : g_cr
            assign msg_rom[g] = C_CR;
        end
        else if (g == MSG_LEN + 1) begin : g_lf
            assign msg_rom[g] = C_LF;
        end
`endif
        else begin : g_pad
            assign msg_rom[g] = '0;
        end
    end

    assign busy_rise = i_tx_busy & ~busy_d;
    assign busy_fall = ~i_tx_busy & busy_d;
    assign trig      = i_rx_valid & (i_rx_data == TRIG);
    assign start     = (state == ST_IDLE) & pend_nz;

    uart_pend_counter #(
        .PEND_MAX (PEND_MAX)
    ) u_pend (
        .clk_x4  (clk_x4),
        .rst_x   (rst_x),
        .inc     (trig),
        .dec     (start),
        .nonzero (pend_nz),
        .ovf     (pend_ovf)
    );

    always_ff @(posedge clk_x4) begin
        if (rst_x) begin
            state      <= ST_IDLE;
            idx        <= '0;
            tmo        <= '0;
            busy_d     <= 1'b0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_data     <= '0;
            o_active   <= 1'b0;
            o_tx_error <= 1'b0;
            o_rx_error <= 1'b0;
            o_pend_ovf <= 1'b0;
        end else begin
            busy_d <= i_tx_busy;
            if (i_rx_valid) o_data <= i_rx_data;

            // clear first so that any set below overrides it
            if (i_clear) begin
                o_tx_error <= 1'b0;
                o_rx_error <= 1'b0;
                o_pend_ovf <= 1'b0;
            end
            if (i_rx_error) o_rx_error <= 1'b1;
            if (i_tx_error) o_tx_error <= 1'b1;
            if (pend_ovf)   o_pend_ovf <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (pend_nz) begin
                        o_tx_data  <= msg_rom[0];
                        o_tx_valid <= 1'b1;
                        idx        <= '0;
                        tmo        <= '0;
                        state      <= ST_SEND;
                        o_active   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (busy_rise) begin
                        o_tx_valid <= 1'b0;
                        state      <= ST_WAIT;
                    end else if (tmo == TMO_W'(TMO_CYCLES - 1)) begin
                        o_tx_valid <= 1'b0;
                        o_tx_data  <= '0;
                        o_tx_error <= 1'b1;
                        state      <= ST_IDLE;
                        o_active   <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (busy_fall) begin
                        if (idx != IDX_W'(NBYTES - 1)) begin
                            idx        <= idx + 1'b1;
                            o_tx_data  <= msg_rom[idx + 1'b1];
                            o_tx_valid <= 1'b1;
                            tmo        <= '0;
                            state      <= ST_SEND;
                        end else begin
                            o_tx_data <= '0;
                            state     <= ST_IDLE;
                            o_active  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
